onebit_cmp_sweeper: RTL and testbench

Self-checking stimulus engine for the one-bit magnitude comparator: drives its `a`/`b` inputs through all four input combinations, samples its `agb`/`eg`/`alb` outputs, and reports per-vector mismatches. It runs on the board as the initiator/checker counterpart of the comparator, replacing the hand-sequenced simulation stimulus so the comparator can be exercised in hardware from a single start pulse.

---
 rtl/onebit_cmp_sweeper.sv | 115 +++++++++++
 tb/tb_onebit_cmp_sweeper.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/onebit_cmp_sweeper.sv
// Stimulus/checker engine for a one-bit magnitude comparator: steps (a,b) through
// 00,10,11,01, samples agb/eg/alb at the end of each hold window and records mismatches.
module onebit_cmp_sweeper #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       agb_in,
  input  logic       eg_in,
  input  logic       alb_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_vec
);

  localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  // Handshake: start is a one-cycle request, accepted only in IDLE (busy=0);
  // done pulses for one cycle in IDLE with pass/err_vec already final.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [3:0]    err_nxt;
  logic [1:0]    idx_inc;
  logic          mismatch;

  assign idx_inc = idx + 2'd1;

  // Expected flags follow the vector currently on a_out/b_out.
  assign mismatch = (agb_in != (a_out & ~b_out)) ||
                    (eg_in  != ~(a_out ^ b_out)) ||
                    (alb_in != (~a_out & b_out));

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    a_nxt     = a_out;
    b_nxt     = b_out;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    pass_nxt  = pass;
    err_nxt   = err_vec;
    case (state)
      IDLE: begin
        a_nxt    = 1'b0;
        b_nxt    = 1'b0;
        busy_nxt = 1'b0;
        if (start) begin
          state_nxt = RUN;
          idx_nxt   = 2'd0;
          cnt_nxt   = '0;
          err_nxt   = 4'b0000;
          pass_nxt  = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt      = '0;
          err_nxt[idx] = err_vec[idx] | mismatch;
          if (idx == 2'd3) begin
            state_nxt = IDLE;
            a_nxt     = 1'b0;
            b_nxt     = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (err_nxt == 4'b0000);
          end else begin
            idx_nxt = idx_inc;
            // Vector order 00,10,11,01: a = idx[1]^idx[0], b = idx[1].
            a_nxt   = idx_inc[1] ^ idx_inc[0];
            b_nxt   = idx_inc[1];
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 2'd0;
      cnt     <= '0;
      a_out   <= 1'b0;
      b_out   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_vec <= 4'b0000;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      cnt     <= cnt_nxt;
      a_out   <= a_nxt;
      b_out   <= b_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      pass    <= pass_nxt;
      err_vec <= err_nxt;
    end
  end

endmodule

// File: tb/tb_onebit_cmp_sweeper.sv
// Bench for onebit_cmp_sweeper: a faultable comparator model feeds the flags back,
// and a vector-table reference predicts per-cycle drive and the final verdict.
module tb_onebit_cmp_sweeper;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       a_out, b_out, busy, done, pass;
  logic       agb_in, eg_in, alb_in;
  logic [3:0] err_vec;

  int         fault_mode = 0;
  logic [2:0] fault_val = 3'b000;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] exp_q[$];

  onebit_cmp_sweeper #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_out(a_out), .b_out(b_out),
    .agb_in(agb_in), .eg_in(eg_in), .alb_in(alb_in),
    .busy(busy), .done(done), .pass(pass), .err_vec(err_vec)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Comparator model: 0 correct, 1 eg stuck 0, 2 agb/alb swapped, 3 all ones, 4 constant fault_val.
  function automatic logic [2:0] model_flags(int mode, logic a, logic b, logic [2:0] fv);
    logic [2:0] ideal;
    ideal = {a > b, a == b, a < b};
    case (mode)
      1:       return {ideal[2], 1'b0, ideal[0]};
      2:       return {ideal[0], ideal[1], ideal[2]};
      3:       return 3'b111;
      4:       return fv;
      default: return ideal;
    endcase
  endfunction

  always_comb {agb_in, eg_in, alb_in} = model_flags(fault_mode, a_out, b_out, fault_val);

  function automatic logic [3:0] expected_err(int mode, logic [2:0] fv);
    logic va[4];
    logic vb[4];
    logic [3:0] e;
    va = '{1'b0, 1'b1, 1'b1, 1'b0};
    vb = '{1'b0, 1'b0, 1'b1, 1'b1};
    e = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (model_flags(mode, va[i], vb[i], fv) != {va[i] > vb[i], va[i] == vb[i], va[i] < vb[i]})
        e[i] = 1'b1;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one sweep from a start pulse; returns on the done cycle.
  // extra_starts re-pulses start at run cycles 3 and 9; hold_checks checks the held result afterwards.
  task automatic run_sweep(input int mode, input logic [2:0] fv, input bit extra_starts,
                           input bit hold_checks);
    logic [3:0] exp_err;
    logic       va[4];
    logic       vb[4];
    va = '{1'b0, 1'b1, 1'b1, 1'b0};
    vb = '{1'b0, 1'b0, 1'b1, 1'b1};
    fault_mode = mode;
    fault_val  = fv;
    exp_q.push_back(expected_err(mode, fv));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_cleared", {28'd0, err_vec}, 32'd0);
    check("pass_cleared", {31'd0, pass}, 32'd0);
    for (int c = 0; c < 4 * H; c++) begin
      check("a_drive", {31'd0, a_out}, {31'd0, va[c / H]});
      check("b_drive", {31'd0, b_out}, {31'd0, vb[c / H]});
      check("busy_run", {31'd0, busy}, 32'd1);
      check("done_low", {31'd0, done}, 32'd0);
      if (extra_starts && (c == 3 || c == 9)) start = 1'b1;
      tick();
      start = 1'b0;
    end
    exp_err = exp_q.pop_front();
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_end", {31'd0, busy}, 32'd0);
    check("err_vec", {28'd0, err_vec}, {28'd0, exp_err});
    check("pass", {31'd0, pass}, {31'd0, exp_err == 4'b0000});
    check("ab_idle", {30'd0, a_out, b_out}, 32'd0);
    if (hold_checks) begin
      tick();
      check("done_once", {31'd0, done}, 32'd0);
      check("err_held", {28'd0, err_vec}, {28'd0, exp_err});
      check("pass_held", {31'd0, pass}, {31'd0, exp_err == 4'b0000});
    end
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    check("rst_outs", {27'd0, a_out, b_out, busy, done, pass}, 32'd0);
    check("rst_err", {28'd0, err_vec}, 32'd0);
    // idle until start lands at edge 10
    repeat (7) tick();
    run_sweep(0, 3'b000, 1'b0, 1'b1);
    run_sweep(1, 3'b000, 1'b0, 1'b1);
    check("eg_stuck_err", {28'd0, err_vec}, 32'h5);
    repeat (3) tick();
    check("eg_stuck_held", {28'd0, err_vec}, 32'h5);
    run_sweep(2, 3'b000, 1'b0, 1'b1);
    check("swap_err", {28'd0, err_vec}, 32'hA);
    run_sweep(3, 3'b000, 1'b0, 1'b1);
    check("multihot_err", {28'd0, err_vec}, 32'hF);
    run_sweep(0, 3'b000, 1'b1, 1'b1);
    // start on the done cycle: the second sweep begins immediately
    run_sweep(1, 3'b000, 1'b0, 1'b0);
    run_sweep(0, 3'b000, 1'b0, 1'b1);

    // reset mid-sweep with a faulty model
    fault_mode = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_outs", {27'd0, a_out, b_out, busy, done, pass}, 32'd0);
    check("midrst_err", {28'd0, err_vec}, 32'd0);
    tick();
    check("midrst_idle", {31'd0, busy}, 32'd0);
    run_sweep(0, 3'b000, 1'b0, 1'b1);
    check("post_rst_pass", {31'd0, pass}, 32'd1);

    for (int n = 0; n < 24; n++) begin
      bit b2b;
      b2b = ($urandom_range(0, 3) == 0);
      run_sweep(int'($urandom_range(0, 4)), 3'($urandom_range(0, 7)),
                bit'($urandom_range(0, 1)), !b2b);
      if (!b2b) repeat ($urandom_range(0, 5)) tick();
    end
    check("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
